// File: rtl/counter_track.sv
// Receive-side tracker for a wrapping step counter stream: acquires lock, flags mismatches, tallies errors.
// Optional COUNTER_TRACK_ERRCNT_EN builds the saturating error tally; otherwise err_cnt is tied to zero.
module counter_track #(
  parameter int unsigned WIDTH    = 36,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned UNLOCK_N = 2,
  parameter int unsigned ERRW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_vld,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             updown,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min_count,
  input  logic [WIDTH-1:0] max_count,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int unsigned RUNW = 4;
  localparam int unsigned EXTW = WIDTH + 1;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [RUNW-1:0]  run_q, run_d;
  logic [RUNW-1:0]  miss_q, miss_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             expw_q, expw_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;

  logic [EXTW-1:0]  sum_x;
  logic [EXTW-1:0]  floor_x;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_wrap;
  logic             match;

  // Successor of the observed value; extra bit keeps the wrap compares exact at full range.
  always_comb begin
    sum_x    = EXTW'(cnt_in) + EXTW'(step);
    floor_x  = EXTW'(min_count) + EXTW'(step);
    nxt_val  = cnt_in;
    nxt_wrap = 1'b0;
    if (updown) begin
      if (sum_x > EXTW'(max_count)) begin
        nxt_val  = min_count;
        nxt_wrap = 1'b1;
      end else begin
        nxt_val = sum_x[WIDTH-1:0];
      end
    end else begin
      if (EXTW'(cnt_in) < floor_x) begin
        nxt_val  = max_count;
        nxt_wrap = 1'b1;
      end else begin
        nxt_val = cnt_in - step;
      end
    end
  end

  assign match = (cnt_in == exp_q);

  // Lock state machine: next state, counters and registered pulse values.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    exp_d   = exp_q;
    expw_d  = expw_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (clr) begin
      state_d = HUNT;
      run_d   = '0;
      miss_d  = '0;
    end else if (cnt_vld) begin
      exp_d  = nxt_val;
      expw_d = nxt_wrap;
      unique case (state_q)
        HUNT: begin
          state_d = VERIFY;
          run_d   = '0;
        end
        VERIFY: begin
          if (match) begin
            wrap_d = expw_q;
            run_d  = run_q + RUNW'(1);
            if (run_q == RUNW'(LOCK_N - 1)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            run_d   = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_d = expw_q;
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + RUNW'(1);
            if (miss_q == RUNW'(UNLOCK_N - 1)) begin
              state_d = HUNT;
              miss_d  = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      run_q    <= '0;
      miss_q   <= '0;
      exp_q    <= '0;
      expw_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      miss_q   <= miss_d;
      exp_q    <= exp_d;
      expw_q   <= expw_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign wrap     = wrap_q;
  assign expected = exp_q;

`ifdef COUNTER_TRACK_ERRCNT_EN
  logic [ERRW-1:0] tally_q, tally_d;

  // Saturating mismatch tally; err_d is only ever set on a counted mismatch.
  always_comb begin
    tally_d = tally_q;
    if (clr) begin
      tally_d = '0;
    end else if (err_d && (tally_q != '1)) begin
      tally_d = tally_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tally_q <= '0;
    end else begin
      tally_q <= tally_d;
    end
  end

  assign err_cnt = tally_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_counter_track.sv
// Scoreboard bench for counter_track: directed scenarios plus randomized streams against a reference model.
module tb_counter_track;
  localparam int unsigned WIDTH    = 36;
  localparam int unsigned ERRW     = 16;
  localparam int unsigned LOCK_N   = 4;
  localparam int unsigned UNLOCK_N = 2;
  localparam longint unsigned MASK = (64'd1 << WIDTH) - 64'd1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             cnt_vld = 1'b0;
  logic [WIDTH-1:0] cnt_in = '0;
  logic             updown = 1'b1;
  logic [WIDTH-1:0] step = WIDTH'(1);
  logic [WIDTH-1:0] min_count = '0;
  logic [WIDTH-1:0] max_count = WIDTH'(7);
  logic             locked, err, wrap;
  logic [WIDTH-1:0] expected;
  logic [ERRW-1:0]  err_cnt;

  counter_track #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .cnt_vld(cnt_vld), .cnt_in(cnt_in),
    .updown(updown), .step(step), .min_count(min_count), .max_count(max_count),
    .locked(locked), .err(err), .wrap(wrap), .expected(expected), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             locked;
    logic             err;
    logic             wrap;
    logic [WIDTH-1:0] expected;
    logic [ERRW-1:0]  err_cnt;
    int               ph;
    int               n;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: 0 hunting, 1 verifying, 2 locked
  int              m_st = 0;
  int              m_run = 0;
  int              m_miss = 0;
  longint unsigned m_exp = 0;
  bit              m_expw = 1'b0;
  int              m_tally = 0;
  int              ph = 0;
  int              n = 0;

  longint unsigned dn_seq[7] = '{11, 8, 5, 2, 11, 8, 5};
  longint unsigned gl_seq[9] = '{0, 1, 2, 3, 4, 9, 6, 7, 8};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req,
                     input int p, input int k);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s ph=%0d n=%0d actual=%0h required=%0h", nm, p, k, act, req);
    end
  endtask

  function automatic void nxt(input longint unsigned v, output longint unsigned r, output bit w);
    longint unsigned st, lo, hi;
    st = longint'(step);
    lo = longint'(min_count);
    hi = longint'(max_count);
    if (updown) begin
      w = (v + st > hi);
      r = w ? lo : v + st;
    end else begin
      w = (v < lo + st);
      r = w ? hi : v - st;
    end
  endfunction

  // Drive one cycle right after a falling edge, advance the model, queue the expected outputs.
  task automatic cyc(input bit c, input bit v, input longint unsigned x);
    exp_t            e;
    longint unsigned xm, nv;
    bit              nw, hit, me, mw;
    xm = x & MASK;
    clr = c;
    cnt_vld = v;
    cnt_in = WIDTH'(xm);
    me = 1'b0;
    mw = 1'b0;
    if (c) begin
      m_st = 0; m_run = 0; m_miss = 0; m_tally = 0;
    end else if (v) begin
      nxt(xm, nv, nw);
      hit = (xm == m_exp);
      case (m_st)
        0: begin m_st = 1; m_run = 0; end
        1: if (hit) begin
             mw = m_expw;
             m_run++;
             if (m_run == LOCK_N) begin m_st = 2; m_miss = 0; end
           end else begin
             me = 1'b1; m_st = 0; m_run = 0;
           end
        default: if (hit) begin
             mw = m_expw; m_miss = 0;
           end else begin
             me = 1'b1;
             m_miss++;
             if (m_miss == UNLOCK_N) begin m_st = 0; m_miss = 0; end
           end
      endcase
      if (me && m_tally < 65535) m_tally++;
      m_exp = nv;
      m_expw = nw;
    end
    e.locked = (m_st == 2);
    e.err = me;
    e.wrap = mw;
    e.expected = WIDTH'(m_exp);
`ifdef COUNTER_TRACK_ERRCNT_EN
    e.err_cnt = ERRW'(m_tally);
`else
    e.err_cnt = '0;
`endif
    e.ph = ph;
    e.n = n;
    sbq.push_back(e);
    n++;
    @(negedge clk);
  endtask

  // Reset pulse that straddles one rising edge and is aligned to neither edge.
  task automatic async_rst();
    clr = 1'b0;
    cnt_vld = 1'b0;
    #2 rst = 1'b0;
    #6 rst = 1'b1;
    m_st = 0; m_run = 0; m_miss = 0; m_exp = 0; m_expw = 1'b0; m_tally = 0;
    @(negedge clk);
  endtask

  // Monitor: outputs must be zero while reset is low, otherwise compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (!rst) begin
        chk("rst_locked", 64'(locked), 64'd0, ph, n);
        chk("rst_err", 64'(err), 64'd0, ph, n);
        chk("rst_wrap", 64'(wrap), 64'd0, ph, n);
        chk("rst_expected", 64'(expected), 64'd0, ph, n);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0, ph, n);
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("locked", 64'(locked), 64'(e.locked), e.ph, e.n);
        chk("err", 64'(err), 64'(e.err), e.ph, e.n);
        chk("wrap", 64'(wrap), 64'(e.wrap), e.ph, e.n);
        chk("expected", 64'(expected), 64'(e.expected), e.ph, e.n);
        chk("err_cnt", 64'(err_cnt), 64'(e.err_cnt), e.ph, e.n);
      end
    end
  end

  initial begin
    bit              c, v;
    longint unsigned x, lo, hi;
    #2 rst = 1'b0;
    #10 rst = 1'b1;
    @(negedge clk);

    ph = 1;
    updown = 1'b1; step = WIDTH'(1); min_count = '0; max_count = WIDTH'(7);
    for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, longint'(i % 8));

    ph = 2;
    cyc(1'b1, 1'b0, 0);
    updown = 1'b0; step = WIDTH'(3); min_count = WIDTH'(2); max_count = WIDTH'(11);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, dn_seq[i]);

    ph = 3;
    cyc(1'b1, 1'b0, 0);
    updown = 1'b1; step = WIDTH'(1); min_count = '0; max_count = WIDTH'(15);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, gl_seq[i]);

    ph = 4;
    cyc(1'b1, 1'b0, 0);
    max_count = WIDTH'(7);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, longint'(i % 8));
      cyc(1'b0, 1'b0, longint'($urandom_range(0, 7)));
      cyc(1'b0, 1'b0, longint'($urandom_range(0, 7)));
    end

    ph = 5;
    cyc(1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, longint'(i));
    cyc(1'b1, 1'b1, 99);
    cyc(1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 5);

    ph = 6;
    for (int i = 6; i < 12; i++) cyc(1'b0, 1'b1, longint'(i % 8));
    async_rst();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, longint'(i % 8));

    ph = 7;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        updown = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          max_count = WIDTH'(MASK);
          min_count = max_count - WIDTH'($urandom_range(0, 40));
        end else begin
          min_count = WIDTH'($urandom_range(0, 20));
          max_count = min_count + WIDTH'($urandom_range(0, 30));
        end
        step = WIDTH'($urandom_range(0, 5));
      end
      c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) begin
        x = m_exp;
      end else begin
        lo = longint'(min_count);
        hi = longint'(max_count);
        x = lo + ({$urandom, $urandom} % (hi - lo + 1));
      end
      cyc(c, v, x);
    end

    clr = 1'b0;
    cnt_vld = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
